// File: rtl/psum_output_buffer.sv
// psum_output_buffer
// Small FIFO between the PE write path and the downstream consumer. It holds
// partial sums and marks the last psum of each ofmap row. It also keeps a
// sticky flag that records any push attempted while the buffer was full.
module psum_output_buffer #(
    parameter int CONFIG_BIT = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CONFIG_BIT-1:0] psum_in,
    input  logic                  psum_wen,
    output logic                  ready,
    input  logic [CONFIG_BIT-1:0] row_len,
    input  logic                  flush,
    output logic [CONFIG_BIT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [CONFIG_BIT-1:0] ROW_ONE  = CONFIG_BIT'(1);

    logic [CONFIG_BIT-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [CONFIG_BIT-1:0] row_cnt_q, row_cnt_d;
    logic                  overflow_q, overflow_d;

    logic                  push;
    logic                  pop;
    logic [CONFIG_BIT-1:0] last_idx;

    // Handshake decode and row-end index. A row_len of 0 behaves like 1, so
    // the last index is 0 in both cases.
    always_comb begin
        ready     = (count_q < FULL_CNT);
        out_valid = (count_q != '0);
        push      = psum_wen & ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        last_idx  = (row_len == '0) ? '0 : (row_len - ROW_ONE);
        out_last  = out_valid & (row_cnt_q == last_idx);
        out_data  = mem_q[rptr_q];
        overflow  = overflow_q;
        count     = count_q;
    end

    // Next-state for pointers, occupancy, row position and the sticky flag.
    // Flush wins over any push or pop in the same cycle, but it leaves the
    // overflow flag alone.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q | (psum_wen & ~ready);

        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            row_cnt_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
                // Wrap at or past the row end. If row_len shrank below the
                // current position, the row still restarts cleanly.
                row_cnt_d = (row_cnt_q >= last_idx) ? '0 : (row_cnt_q + ROW_ONE);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers. An asynchronous reset drops everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array. It needs no reset because out_valid gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= psum_in;
        end
    end

endmodule

// File: tb/tb_psum_output_buffer.sv
// Bench for psum_output_buffer: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_psum_output_buffer;

    localparam int CB    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CB-1:0] psum_in;
    logic          psum_wen;
    logic          ready;
    logic [CB-1:0] row_len;
    logic          flush;
    logic [CB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          overflow;
    logic [AW:0]   count;

    int n_vec = 0;
    int n_err = 0;

    logic [CB-1:0] q[$];
    int            m_row;
    bit            m_ovf;

    psum_output_buffer #(.CONFIG_BIT(CB), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .psum_in  (psum_in),
        .psum_wen (psum_wen),
        .ready    (ready),
        .row_len  (row_len),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic int eff_len();
        return (row_len == 0) ? 1 : int'(row_len);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("ready", 32'(ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_last", 32'(out_last), 32'((q.size() != 0) && (m_row == eff_len() - 1)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    endtask

    // One clock cycle. Inputs are applied at the falling edge, the model
    // steps at the rising edge, and outputs are checked at the next falling edge.
    task automatic cycle(input logic wen, input logic [CB-1:0] din, input logic ordy,
                         input logic fl);
        bit full, do_push, do_pop;
        psum_wen  = wen;
        psum_in   = din;
        out_ready = ordy;
        flush     = fl;
        full      = (q.size() == DEPTH);
        do_push   = wen && !full && !fl;
        do_pop    = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (wen && full) m_ovf = 1'b1;
        if (fl) begin
            q.delete();
            m_row = 0;
        end else begin
            if (do_pop) begin
                q.delete(0);
                m_row = (m_row >= eff_len() - 1) ? 0 : m_row + 1;
            end
            if (do_push) q.push_back(din);
        end
        @(negedge clk);
        psum_wen  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_row = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        logic [CB-1:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b0; psum_in = '0; psum_wen = 1'b0; row_len = 8'd1;
        flush = 1'b0; out_ready = 1'b0;
        model_reset();

        // Reset state
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill, then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, exp_d[i], 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(out_data), 32'(exp_d[i]));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Overflow while full; the flag survives a flush
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_no55", 32'(out_data == 8'h55), 32'd0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_after_flush", 32'(overflow), 32'd1);

        // Row marking, row_len=3: last flag on the 3rd and 6th pops
        row_len = 8'd3;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
            chk("row3_last", 32'(out_last), 32'((k % 3) == 2));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        row_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 8'(8'h90 + k), 1'b0, 1'b0);
            chk("row0_last", 32'(out_last), 32'd1);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Concurrent push and pop at count=2, and push+pop request when empty
        row_len = 8'd1;
        cycle(1'b1, 8'hA0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b1, 1'b0);
        chk("conc_count", 32'(count), 32'd2);
        chk("conc_head", 32'(out_data), 32'hA1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hB1, 1'b1, 1'b0);
        chk("empty_push_count", 32'(count), 32'd1);
        chk("empty_push_data", 32'(out_data), 32'hB1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush alongside a push with count=3, row position 1
        row_len = 8'd3;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd3);
        cycle(1'b1, 8'hCC, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        chk("flush_row0", 32'(out_last), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_row_last", 32'(out_last), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        cycle(1'b1, 8'hE0, 1'b0, 1'b0);
        cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk("first_push", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap over 10 push/pop pairs
        row_len = 8'd1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            chk("wrap_data", 32'(out_data), 32'(8'h20 + i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) row_len = 8'($urandom_range(0, 5));
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_output_buffer.md
PSUM_OUTPUT_BUFFER -- requirements
Module: psum_output_buffer

Interface
REQ-001 The block SHALL take parameters as follows, one per line: name, default, meaning.
- CONFIG_BIT, 8, psum data width; also the width of row_len.
- DEPTH, 4, number of FIFO entries (power of two, at least 2).
- ADDR_WIDTH, 2, log2(DEPTH); pointer width.
REQ-002 The block SHALL expose ports as follows, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous, active-low reset (asserted when 0).
- psum_in, in, CONFIG_BIT, psum from the PE write path.
- psum_wen, in, 1, one-cycle push strobe from the PE write controller.
- ready, out, 1, buffer can accept a push; drives the PE write controller ready input.
- row_len, in, CONFIG_BIT, outputs per ofmap row; a value of 0 is treated as 1.
- flush, in, 1, synchronous discard of all contents.
- out_data, out, CONFIG_BIT, head-of-FIFO psum.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, downstream accepts out_data.
- out_last, out, 1, the head entry is the last psum of a row.
- overflow, out, 1, sticky flag: a push was attempted while full.
- count, out, ADDR_WIDTH+1, current occupancy.

Function
REQ-003 The block SHALL be a DEPTH-entry FIFO with write pointer wptr, read pointer rptr and an occupancy register count, all registered and updated only on the rising edge of clk.
REQ-004 ready SHALL be asserted exactly when count < DEPTH, decoded combinationally from the count register.
REQ-005 A push SHALL occur when psum_wen=1, count<DEPTH and flush=0; the push writes psum_in to mem[wptr] and increments wptr modulo DEPTH.
REQ-006 out_valid SHALL be asserted exactly when count>0; out_data SHALL be mem[rptr], read combinationally.
REQ-007 A pop SHALL occur when out_valid=1, out_ready=1 and flush=0; the pop increments rptr modulo DEPTH.
REQ-008 Latency: a push SHALL be visible on out_data/out_valid in the cycle after the clock edge that writes it; there is no bypass when the FIFO is empty.
REQ-009 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-010 When full, a simultaneous pop and psum_wen SHALL perform the pop only; the push is refused because ready=0.
REQ-011 When empty, a simultaneous psum_wen and out_ready SHALL perform the push only.
REQ-012 psum_wen asserted while count==DEPTH SHALL drop the data, leave the FIFO state unchanged, and set overflow=1 on the next edge.
REQ-013 overflow SHALL remain set until reset; flush SHALL NOT clear it.
REQ-014 Row tracking: a row counter row_cnt (CONFIG_BIT bits) SHALL increment on each pop.
REQ-015 On a pop with row_cnt == eff_len-1, where eff_len = (row_len==0) ? 1 : row_len, row_cnt SHALL wrap to 0.
REQ-016 out_last SHALL equal out_valid AND (row_cnt == eff_len-1).
REQ-017 row_len changes SHALL take effect immediately on the comparison; if row_cnt >= eff_len, the next pop SHALL wrap row_cnt to 0 and out_last SHALL stay 0 for that entry.
REQ-018 flush=1 SHALL clear wptr, rptr, count and row_cnt to 0 on the next edge, overriding any push or pop in the same cycle; memory contents need not be cleared.
REQ-019 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no dead cycle.

Reset
REQ-020 While rst=0, asynchronously: wptr=0, rptr=0, count=0, row_cnt=0, overflow=0; hence ready=1, out_valid=0, out_last=0. out_data is don't-care.
REQ-021 Reset deassertion SHALL be sampled by clk; the first push can occur on the first edge after rst rises.
REQ-022 Reset asserted mid-operation SHALL discard all contents immediately, with no pending push or pop completing.

Verification
REQ-023 Fill/drain: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, ready=0; then out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
REQ-024 Overflow: with the FIFO full, pulse psum_wen with 0x55 -> overflow=1, count=4, and 0x55 never appears on out_data; overflow stays 1 after flush.
REQ-025 Row marking: row_len=3, push 6 psums, pop all -> out_last=1 on the 3rd and 6th pops only; row_len=0 -> out_last on every pop.
REQ-026 Concurrency: count=2, push and pop in the same cycle -> count stays 2 and FIFO order is preserved; when empty, push+out_ready -> count=1, no pop.
REQ-027 Flush/reset: count=3 with row_cnt=1, assert flush together with a push -> count=0, row_cnt=0, push ignored; drop rst mid-stream -> out_valid=0 and ready=1 without waiting for a clock edge.
REQ-028 Wrap: run 10 push/pop pairs with DEPTH=4 -> data order is intact across pointer wrap.
